// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side bundle: address/data to the combinational imem plus the instr handshake to decode.
// No storage; no latency.
// Backpressure is carried by instr_ready against instr_valid.
interface imem_fetch_ctrl_if #(
    parameter int n = 32,
    parameter int r = 6
);
    logic [r-1:0] imem_addr;
    logic [n-1:0] imem_data;
    logic [n-1:0] instr;
    logic [r-1:0] instr_pc;
    logic         instr_valid;
    logic         instr_ready;

    modport master (
        output imem_addr,
        input  imem_data,
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns pc, reads combinational imem, registers instr for decode (optional FETCH_PERF_CNT_EN counters).
// Latency: address presented in cycle k appears on instr in cycle k+1.
// Backpressure: instr_valid && !instr_ready holds instr, instr_pc and pc.
module imem_fetch_ctrl #(
    parameter int           n         = 32,
    parameter int           r         = 6,
    parameter logic [r-1:0] LAST_ADDR = {r{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [r-1:0]     start_addr,
    input  logic             halt,
    input  logic             br_valid,
    input  logic [r-1:0]     br_target,
    output logic             busy,
    output logic             done,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]      fetch_count,
    output logic [15:0]      flush_count,
`endif
    imem_fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t       state, state_nxt;
    logic [r-1:0] pc, pc_nxt;
    logic         valid_nxt;
    logic         fire;
    logic         redirect;
    logic         launch;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        valid_nxt = bus.instr_valid;
        fire      = 1'b0;
        redirect  = 1'b0;
        launch    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    launch    = 1'b1;
                    pc_nxt    = start_addr;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (br_valid) begin
                    redirect = 1'b1;
                end else if (halt) begin
                    state_nxt = DRAIN;
                    if (bus.instr_ready) valid_nxt = 1'b0;
                end else if (!bus.instr_valid || bus.instr_ready) begin
                    fire      = 1'b1;
                    valid_nxt = 1'b1;
                    // Last word: stop here rather than wrap pc back to 0.
                    if (pc == LAST_ADDR) state_nxt = DRAIN;
                    else                 pc_nxt    = pc + 1'b1;
                end
            end
            DRAIN: begin
                if (br_valid) begin
                    redirect = 1'b1;
                end else begin
                    if (bus.instr_ready) valid_nxt = 1'b0;
                    if (!bus.instr_valid || bus.instr_ready) state_nxt = DONE;
                end
            end
            DONE: begin
                if (br_valid) begin
                    redirect = 1'b1;
                end else if (start) begin
                    launch    = 1'b1;
                    pc_nxt    = start_addr;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A redirect flushes whatever is pending, even if decode is taking it this cycle.
        if (redirect) begin
            pc_nxt    = br_target;
            valid_nxt = 1'b0;
            state_nxt = FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc              <= '0;
            bus.instr       <= '0;
            bus.instr_pc    <= '0;
            bus.instr_valid <= 1'b0;
        end else begin
            pc              <= pc_nxt;
            bus.instr_valid <= valid_nxt;
            if (fire) begin
                bus.instr    <= bus.imem_data;
                bus.instr_pc <= pc;
            end
        end
    end

    assign bus.imem_addr = pc;
    assign busy          = (state == FETCH) || (state == DRAIN);
    assign done          = (state == DONE);

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else if (launch) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            if (fire && fetch_count != '1) fetch_count <= fetch_count + 32'd1;
            if (redirect && bus.instr_valid && flush_count != '1)
                flush_count <= flush_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_imem_fetch_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [5:0] start_addr;
    logic       halt;
    logic       br_valid;
    logic [5:0] br_target;
    logic       busy;
    logic       done;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [15:0] flush_count;
`endif
    int checks = 0;
    int errors = 0;

    imem_fetch_ctrl_if #(.n(32), .r(6)) bus ();

    imem_fetch_ctrl #(.n(32), .r(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .halt       (halt),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .busy       (busy),
        .done       (done),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count(fetch_count),
        .flush_count(flush_count),
`endif
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [5:0] a);
        return 32'hC0DE_0000 | ({26'd0, a} * 32'd3 + 32'd1);
    endfunction

    assign bus.imem_data = mem_word(bus.imem_addr);

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; start_addr = '0; halt = 1'b0;
        br_valid = 1'b0; br_target = '0; bus.instr_ready = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0h exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%0h exp=0", done); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0h exp=0", bus.instr_valid); end
        checks++; if (bus.instr !== 32'h0) begin errors++; $display("FAIL rst_instr got=%0h exp=0", bus.instr); end
        checks++; if (bus.instr_pc !== 6'h0) begin errors++; $display("FAIL rst_pc got=%0h exp=0", bus.instr_pc); end
        checks++; if (bus.imem_addr !== 6'h0) begin errors++; $display("FAIL rst_addr got=%0h exp=0", bus.imem_addr); end
        rst_n = 1'b1;
        step();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_hold busy=%0h done=%0h exp=0,0", busy, done); end
    endtask

    task automatic test_full_run();
        start = 1'b1; start_addr = 6'd0; bus.instr_ready = 1'b1;
        step();
        start = 1'b0;
        checks++; if (busy !== 1'b1 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL run_launch busy=%0h valid=%0h exp=1,0", busy, bus.instr_valid); end
        for (int i = 0; i < 64; i++) begin
            step();
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 6'(i) || bus.instr !== mem_word(6'(i))) begin
                errors++;
                $display("FAIL run_seq%0d valid=%0h pc=%0h instr=%0h exp=1,%0h,%0h", i, bus.instr_valid, bus.instr_pc, bus.instr, i, mem_word(6'(i)));
            end
        end
        checks++; if (bus.imem_addr !== 6'd63 || busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL run_drain addr=%0h busy=%0h done=%0h exp=3f,1,0", bus.imem_addr, busy, done); end
        step();
        checks++; if (done !== 1'b1 || busy !== 1'b0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL run_done done=%0h busy=%0h valid=%0h exp=1,0,0", done, busy, bus.instr_valid); end
        step();
        checks++; if (bus.instr_valid !== 1'b0 || bus.instr_pc !== 6'd63) begin errors++; $display("FAIL run_nowrap valid=%0h pc=%0h exp=0,3f", bus.instr_valid, bus.instr_pc); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (fetch_count !== 32'd64) begin errors++; $display("FAIL run_fcnt got=%0d exp=64", fetch_count); end
`endif
    endtask

    task automatic test_backpressure();
        start = 1'b1; start_addr = 6'd2; bus.instr_ready = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step(); step();
        checks++; if (bus.instr_pc !== 6'd5 || bus.instr_valid !== 1'b1) begin errors++; $display("FAIL bp_pre pc=%0h valid=%0h exp=5,1", bus.instr_pc, bus.instr_valid); end
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.instr_pc !== 6'd5 || bus.instr !== mem_word(6'd5) || bus.imem_addr !== 6'd6 || bus.instr_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold%0d pc=%0h instr=%0h addr=%0h exp=5,%0h,6", i, bus.instr_pc, bus.instr, bus.imem_addr, mem_word(6'd5));
            end
        end
        bus.instr_ready = 1'b1;
        step();
        checks++; if (bus.instr_pc !== 6'd6 || bus.instr !== mem_word(6'd6)) begin errors++; $display("FAIL bp_release pc=%0h instr=%0h exp=6,%0h", bus.instr_pc, bus.instr, mem_word(6'd6)); end
        step();
        checks++; if (bus.instr_pc !== 6'd7 || bus.instr_valid !== 1'b1) begin errors++; $display("FAIL bp_next pc=%0h valid=%0h exp=7,1", bus.instr_pc, bus.instr_valid); end
    endtask

    task automatic test_redirect();
        br_valid = 1'b1; br_target = 6'd3;
        step();
        br_valid = 1'b0;
        checks++; if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 6'd3) begin errors++; $display("FAIL br1_flush valid=%0h addr=%0h exp=0,3", bus.instr_valid, bus.imem_addr); end
        step();
        checks++; if (bus.instr_pc !== 6'd3 || bus.instr_valid !== 1'b1) begin errors++; $display("FAIL br1_fetch pc=%0h valid=%0h exp=3,1", bus.instr_pc, bus.instr_valid); end
        bus.instr_ready = 1'b0; br_valid = 1'b1; br_target = 6'h20;
        step();
        br_valid = 1'b0; bus.instr_ready = 1'b1;
        checks++; if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 6'h20) begin errors++; $display("FAIL br2_flush valid=%0h addr=%0h exp=0,20", bus.instr_valid, bus.imem_addr); end
        step();
        checks++; if (bus.instr_pc !== 6'h20 || bus.instr !== mem_word(6'h20)) begin errors++; $display("FAIL br2_first pc=%0h instr=%0h exp=20,%0h", bus.instr_pc, bus.instr, mem_word(6'h20)); end
        step();
        checks++; if (bus.instr_pc !== 6'h21) begin errors++; $display("FAIL br2_second pc=%0h exp=21", bus.instr_pc); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (flush_count !== 16'd2) begin errors++; $display("FAIL br_flush_cnt got=%0d exp=2", flush_count); end
`endif
    endtask

    task automatic test_br_halt();
        br_valid = 1'b1; br_target = 6'h10; halt = 1'b1;
        step();
        br_valid = 1'b0;
        checks++; if (busy !== 1'b1 || bus.imem_addr !== 6'h10 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL brh_win busy=%0h addr=%0h valid=%0h exp=1,10,0", busy, bus.imem_addr, bus.instr_valid); end
        step();
        checks++; if (busy !== 1'b1 || done !== 1'b0 || bus.instr_valid !== 1'b0 || bus.imem_addr !== 6'h10) begin errors++; $display("FAIL brh_drain busy=%0h done=%0h valid=%0h addr=%0h exp=1,0,0,10", busy, done, bus.instr_valid, bus.imem_addr); end
        step();
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL brh_done done=%0h busy=%0h exp=1,0", done, busy); end
        start = 1'b1; start_addr = 6'd9;
        step();
        start = 1'b0;
        checks++; if (busy !== 1'b1 || bus.imem_addr !== 6'd9) begin errors++; $display("FAIL halt_start busy=%0h addr=%0h exp=1,9", busy, bus.imem_addr); end
        step();
        step();
        checks++; if (done !== 1'b1 || bus.instr_pc !== 6'h21 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL halt_zero done=%0h pc=%0h valid=%0h exp=1,21,0", done, bus.instr_pc, bus.instr_valid); end
        halt = 1'b0;
    endtask

    task automatic test_start_busy();
        start = 1'b1; start_addr = 6'h30;
        step();
        start = 1'b0;
        step();
        checks++; if (bus.instr_pc !== 6'h30) begin errors++; $display("FAIL sb_first pc=%0h exp=30", bus.instr_pc); end
        start = 1'b1; start_addr = 6'h05;
        step();
        start = 1'b0;
        checks++; if (bus.instr_pc !== 6'h31 || bus.imem_addr !== 6'h32) begin errors++; $display("FAIL sb_ignored pc=%0h addr=%0h exp=31,32", bus.instr_pc, bus.imem_addr); end
        halt = 1'b1;
        step();
        checks++; if (busy !== 1'b1 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL sb_halt busy=%0h valid=%0h exp=1,0", busy, bus.instr_valid); end
        step();
        halt = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL sb_done got=%0h exp=1", done); end
        start = 1'b1; start_addr = 6'h3E;
        step();
        start = 1'b0;
        checks++; if (bus.imem_addr !== 6'h3E || busy !== 1'b1) begin errors++; $display("FAIL sb_accept addr=%0h busy=%0h exp=3e,1", bus.imem_addr, busy); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (fetch_count !== 32'd0 || flush_count !== 16'd0) begin errors++; $display("FAIL sb_cnt_clr fetch=%0d flush=%0d exp=0,0", fetch_count, flush_count); end
`endif
        step();
        step();
        checks++; if (bus.instr_pc !== 6'h3F || bus.imem_addr !== 6'h3F || busy !== 1'b1) begin errors++; $display("FAIL sb_last pc=%0h addr=%0h busy=%0h exp=3f,3f,1", bus.instr_pc, bus.imem_addr, busy); end
        step();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL sb_end done=%0h exp=1", done); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL sb_fcnt got=%0d exp=2", fetch_count); end
`endif
    endtask

    task automatic test_async_reset();
        start = 1'b1; start_addr = 6'h10;
        step();
        start = 1'b0;
        step();
        checks++; if (bus.instr_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL ar_pre valid=%0h busy=%0h exp=1,1", bus.instr_valid, busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.instr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ar_drop valid=%0h busy=%0h done=%0h exp=0,0,0", bus.instr_valid, busy, done); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if (busy !== 1'b0 || done !== 1'b0 || bus.imem_addr !== 6'h0) begin errors++; $display("FAIL ar_idle busy=%0h done=%0h addr=%0h exp=0,0,0", busy, done, bus.imem_addr); end
        start = 1'b1; start_addr = 6'd7;
        step();
        start = 1'b0;
        step();
        checks++; if (bus.instr_pc !== 6'd7 || bus.instr !== mem_word(6'd7) || bus.instr_valid !== 1'b1) begin errors++; $display("FAIL ar_restart pc=%0h instr=%0h exp=7,%0h", bus.instr_pc, bus.instr, mem_word(6'd7)); end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_backpressure();
        test_redirect();
        test_br_halt();
        test_start_busy();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Fetch sequencer for the 2^r x n combinational instruction memory `imem`.
- Owns the program counter and drives `imem.addr`. Registers `imem.readData` into an output instruction register.
- Hands instructions to decode over a valid/ready handshake.
- Supports start, halt, branch redirect and end-of-memory termination.

Parameters:
- n, 32, instruction width (matches imem data width)
- r, 6, address width (matches imem address width; memory depth 2^r words)
- LAST_ADDR, 2^r-1, highest word address fetched before automatic stop

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  pulse: begin fetching at start_addr (honoured only in IDLE or DONE)
- start_addr  input  r  first fetch address
- halt  input  1  level: stop issuing new fetches
- br_valid  input  1  pulse: redirect fetch to br_target
- br_target  input  r  redirect address
- imem_addr  output  r  address to imem (= pc, combinational from register)
- imem_data  input  n  imem readData
- instr  output  n  registered instruction to decode
- instr_pc  output  r  address that instr was fetched from
- instr_valid  output  1  instr holds a live instruction
- instr_ready  input  1  decode accepts instr this cycle
- busy  output  1  high in FETCH or DRAIN
- done  output  1  high in DONE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=0, instr=0, instr_pc=0, instr_valid=0, busy=0, done=0.
  - Takes effect immediately mid-operation; no fetch completes that cycle.
- States: IDLE, FETCH, DRAIN, DONE. Encoding is free; outputs must not glitch (busy/done decoded from the state register).
- IDLE: start=1 -> pc<=start_addr, go FETCH. All other inputs ignored.
- FETCH, fetch condition: fire = !instr_valid || instr_ready. When fire:
  - instr<=imem_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1.
  - Read latency: address presented in cycle k, data visible on instr in cycle k+1.
- FETCH, backpressure: when instr_valid=1 and instr_ready=0, instr/instr_pc/pc all hold. No instruction is lost or duplicated.
- FETCH, acceptance without refill: if instr_ready=1 and no refill occurs, instr_valid<=0.
- Termination:
  - A fire with pc==LAST_ADDR -> go DRAIN; pc does not wrap (holds LAST_ADDR).
  - halt=1 in FETCH -> no fire this cycle, go DRAIN.
- DRAIN: no fetches. instr_valid clears on instr_ready. When instr_valid==0 (or clears this cycle) -> DONE.
- DONE: done=1. start=1 -> pc<=start_addr, go FETCH.
- Redirect (br_valid=1 in FETCH, DRAIN or DONE):
  - pc<=br_target, instr_valid<=0 (flush the pending instruction, even if instr_ready=1), no fire that cycle, next state FETCH.
- Priority when simultaneous: rst_n > br_valid > halt > LAST_ADDR termination > normal fire.
- start is ignored while busy.
- br_valid in IDLE is ignored.
- halt held high in DONE/IDLE has no effect on start. If still high on the first FETCH cycle, it goes DRAIN immediately with zero fetches.
- pc+1 arithmetic is r bits; overflow can only arise via br_target=LAST_ADDR=2^r-1, which is covered by the termination rule.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN
- Defined:
  - Adds output fetch_count [31:0], counting fires (saturating at 2^32-1).
  - Adds output flush_count [15:0], counting redirects that discarded a valid instr (saturating).
  - Both reset to 0 on rst_n=0 and on start acceptance.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, start_addr=0, instr_ready=1 held -> instr_pc sequence 0,1,2,...,63 one per cycle from 1 cycle after start; instr matches imem words; after pc 63: DRAIN, then done=1 two cycles after the last fire; no pc 0 refetch.
- Backpressure: instr_ready=0 for 3 cycles while instr_pc=5 -> instr/instr_pc stable for 3 cycles; on release, next instr_pc=6, no gap, no duplicate.
- Redirect: br_valid with br_target=0x20 while instr_pc=3 is valid and instr_ready=0 -> instr_valid=0 next cycle, then instr_pc=0x20,0x21; with FETCH_PERF_CNT_EN, flush_count=1.
- Simultaneous br_valid and halt in FETCH -> redirect wins: state FETCH, pc=br_target; a halt held the following cycle drives DRAIN, then DONE.
- rst_n asserted asynchronously mid-FETCH (between clock edges) -> instr_valid, busy and done drop to 0 immediately; after release, state IDLE and start_addr=7 restarts at instr_pc=7.
- start asserted while busy and in DONE -> ignored while busy; accepted in DONE with pc=start_addr; fetch_count reset to 0 when the macro is defined.
